// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game sequencer: alternates user (O) and engine (X) moves,
// validates each move against the board, consults an external result
// checker, reports the outcome and waits for the display to drain.
// Optional macro TTT_SCORE_EN adds saturating win/draw tallies; when it is
// undefined the tally outputs are tied to zero.
//
// state       | meaning
// ------------+--------------------------------------------------------
// INIT        | clear board and result, choose who moves first
// GET_USER    | user handshake open, wait for a move
// APPLY_USER  | validate user move, write O or pulse bad-move
// CHECK_USER  | sample checker after the O move
// REQ_X       | request a move from the engine, wait for ack
// APPLY_X     | validate engine move, write X or fail
// CHECK_X     | sample checker after the X move
// REPORT      | one-cycle result strobe, bump tallies
// WAIT_DISP   | one cycle for display busy to assert
// WAIT_DISP2  | wait for display busy to drop
// ERROR       | illegal engine move or impossible result, restart
module ttt_game_ctrl #(
    parameter int CELLS   = 9,
    parameter int MOVE_W  = 4,
    parameter int SCORE_W = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_x_first,
    input  logic                 i_user_valid,
    input  logic [MOVE_W-1:0]    i_user_move,
    output logic                 o_user_ready,
    output logic                 o_x_req,
    input  logic                 i_x_ack,
    input  logic [MOVE_W-1:0]    i_x_move,
    input  logic [1:0]           i_result,
    input  logic                 i_disp_busy,
    output logic [2*CELLS-1:0]   o_board,
    output logic [1:0]           o_result,
    output logic                 o_result_stb,
    output logic                 o_bad_move,
    output logic [SCORE_W-1:0]   o_x_wins,
    output logic [SCORE_W-1:0]   o_o_wins,
    output logic [SCORE_W-1:0]   o_draws
);

    localparam logic [3:0] S_INIT       = 4'd0;
    localparam logic [3:0] S_GET_USER   = 4'd1;
    localparam logic [3:0] S_APPLY_USER = 4'd2;
    localparam logic [3:0] S_CHECK_USER = 4'd3;
    localparam logic [3:0] S_REQ_X      = 4'd4;
    localparam logic [3:0] S_APPLY_X    = 4'd5;
    localparam logic [3:0] S_CHECK_X    = 4'd6;
    localparam logic [3:0] S_REPORT     = 4'd7;
    localparam logic [3:0] S_WAIT_DISP  = 4'd8;
    localparam logic [3:0] S_WAIT_DISP2 = 4'd9;
    localparam logic [3:0] S_ERROR      = 4'd10;

    localparam logic [1:0] RES_NONE = 2'd0;
    localparam logic [1:0] RES_XWIN = 2'd1;
    localparam logic [1:0] RES_OWIN = 2'd2;
    localparam logic [1:0] RES_DRAW = 2'd3;

    localparam logic [1:0] MARK_O = 2'b01;
    localparam logic [1:0] MARK_X = 2'b11;

    logic [3:0]        state;
    logic [3:0]        state_nxt;
    logic [MOVE_W-1:0] move;
    logic              cell_free;
    logic              write_en;
    logic [1:0]        mark;

    assign o_user_ready = (state == S_GET_USER);
    assign o_x_req      = (state == S_REQ_X);
    assign o_result_stb = (state == S_REPORT);
    assign o_bad_move   = (state == S_APPLY_USER) && !cell_free;
    assign write_en     = ((state == S_APPLY_USER) || (state == S_APPLY_X)) && cell_free;
    assign mark         = (state == S_APPLY_USER) ? MARK_O : MARK_X;

    // Captured move is legal only if it names an existing, empty cell;
    // an out-of-range index matches no cell and so is never free.
    always_comb begin
        cell_free = 1'b0;
        for (int k = 0; k < CELLS; k++) begin
            if ((move == MOVE_W'(k)) && (o_board[2*k +: 2] == 2'b00)) begin
                cell_free = 1'b1;
            end
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = S_INIT;
        case (state)
            S_INIT:       state_nxt = i_x_first ? S_REQ_X : S_GET_USER;
            S_GET_USER:   state_nxt = i_user_valid ? S_APPLY_USER : S_GET_USER;
            S_APPLY_USER: state_nxt = cell_free ? S_CHECK_USER : S_GET_USER;
            S_CHECK_USER: begin
                case (i_result)
                    RES_NONE: state_nxt = S_REQ_X;
                    RES_XWIN: state_nxt = S_ERROR;
                    default:  state_nxt = S_REPORT;
                endcase
            end
            S_REQ_X:      state_nxt = i_x_ack ? S_APPLY_X : S_REQ_X;
            S_APPLY_X:    state_nxt = cell_free ? S_CHECK_X : S_ERROR;
            S_CHECK_X: begin
                case (i_result)
                    RES_NONE: state_nxt = S_GET_USER;
                    RES_OWIN: state_nxt = S_ERROR;
                    default:  state_nxt = S_REPORT;
                endcase
            end
            S_REPORT:     state_nxt = S_WAIT_DISP;
            S_WAIT_DISP:  state_nxt = S_WAIT_DISP2;
            S_WAIT_DISP2: state_nxt = i_disp_busy ? S_WAIT_DISP2 : S_INIT;
            S_ERROR:      state_nxt = S_INIT;
            default:      state_nxt = S_INIT;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= S_INIT;
        else          state <= state_nxt;
    end

    // Capture the move index from whichever side completes its handshake.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            move <= '0;
        end else if ((state == S_GET_USER) && i_user_valid) begin
            move <= i_user_move;
        end else if ((state == S_REQ_X) && i_x_ack) begin
            move <= i_x_move;
        end
    end

    // Board: cleared on INIT, one cell written per legal move.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_board <= '0;
        end else if (state == S_INIT) begin
            o_board <= '0;
        end else if (write_en) begin
            for (int k = 0; k < CELLS; k++) begin
                if (move == MOVE_W'(k)) o_board[2*k +: 2] <= mark;
            end
        end
    end

    // Final result latch; holds through REPORT and the display wait.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_result <= RES_NONE;
        end else if (state == S_INIT) begin
            o_result <= RES_NONE;
        end else if ((state == S_CHECK_USER) &&
                     ((i_result == RES_OWIN) || (i_result == RES_DRAW))) begin
            o_result <= i_result;
        end else if ((state == S_CHECK_X) &&
                     ((i_result == RES_XWIN) || (i_result == RES_DRAW))) begin
            o_result <= i_result;
        end
    end

`ifdef TTT_SCORE_EN
    // Saturating tallies, bumped once per reported game, cleared only by reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_x_wins <= '0;
            o_o_wins <= '0;
            o_draws  <= '0;
        end else if (state == S_REPORT) begin
            case (o_result)
                RES_XWIN: if (o_x_wins != '1) o_x_wins <= o_x_wins + SCORE_W'(1);
                RES_OWIN: if (o_o_wins != '1) o_o_wins <= o_o_wins + SCORE_W'(1);
                RES_DRAW: if (o_draws  != '1) o_draws  <= o_draws  + SCORE_W'(1);
                default: ;
            endcase
        end
    end
`else
    assign o_x_wins = '0;
    assign o_o_wins = '0;
    assign o_draws  = '0;
`endif

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed bench for ttt_game_ctrl: a default 3x3 instance plus a 16-cell,
// 2-bit-score instance driven by the same inputs while moves stay below 9.
module tb_ttt_game_ctrl;

`ifdef TTT_SCORE_EN
    localparam bit SCORE_ON = 1'b1;
`else
    localparam bit SCORE_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        x_first = 1'b0;
    logic        user_valid = 1'b0;
    logic [3:0]  user_move = '0;
    logic        x_ack = 1'b0;
    logic [3:0]  x_move = '0;
    logic [1:0]  result = 2'd0;
    logic        disp_busy = 1'b0;

    logic        user_ready, x_req, result_stb, bad_move;
    logic [17:0] board;
    logic [1:0]  res_out;
    logic [7:0]  x_wins, o_wins, draws;

    logic        user_ready2, x_req2, result_stb2, bad_move2;
    logic [31:0] board2;
    logic [1:0]  res_out2;
    logic [1:0]  x_wins2, o_wins2, draws2;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ttt_game_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_x_first(x_first),
        .i_user_valid(user_valid), .i_user_move(user_move), .o_user_ready(user_ready),
        .o_x_req(x_req), .i_x_ack(x_ack), .i_x_move(x_move),
        .i_result(result), .i_disp_busy(disp_busy), .o_board(board),
        .o_result(res_out), .o_result_stb(result_stb), .o_bad_move(bad_move),
        .o_x_wins(x_wins), .o_o_wins(o_wins), .o_draws(draws)
    );

    ttt_game_ctrl #(.CELLS(16), .MOVE_W(4), .SCORE_W(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_x_first(x_first),
        .i_user_valid(user_valid), .i_user_move(user_move), .o_user_ready(user_ready2),
        .o_x_req(x_req2), .i_x_ack(x_ack), .i_x_move(x_move),
        .i_result(result), .i_disp_busy(disp_busy), .o_board(board2),
        .o_result(res_out2), .o_result_stb(result_stb2), .o_bad_move(bad_move2),
        .o_x_wins(x_wins2), .o_o_wins(o_wins2), .o_draws(draws2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic user_play(input logic [3:0] m);
        user_valid = 1'b1;
        user_move  = m;
        tick();
        user_valid = 1'b0;
    endtask

    task automatic x_play(input logic [3:0] m);
        x_ack  = 1'b1;
        x_move = m;
        tick();
        x_ack  = 1'b0;
    endtask

    initial begin
        // reset, user moves first
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_ready", 32'(user_ready), 32'd0);
        check("rst_xreq", 32'(x_req), 32'd0);
        check("rst_board", 32'(board), 32'd0);
        check("rst_result", 32'(res_out), 32'd0);
        tick();                                   // GET_USER
        check("ready_get_user", 32'(user_ready), 32'd1);

        // user 4, engine 0
        user_play(4'd4);                          // APPLY_USER
        check("ready_drop", 32'(user_ready), 32'd0);
        check("no_bad_legal", 32'(bad_move), 32'd0);
        tick();                                   // CHECK_USER
        check("board_o4", 32'(board), 32'h100);
        tick();                                   // REQ_X
        check("xreq_high", 32'(x_req), 32'd1);
        tick();
        check("xreq_hold", 32'(x_req), 32'd1);
        x_play(4'd0);                             // APPLY_X
        check("xreq_low_after_ack", 32'(x_req), 32'd0);
        tick();                                   // CHECK_X
        check("board_x0", 32'(board), 32'h103);
        check("board2_x0", board2, 32'h103);
        tick();                                   // GET_USER
        check("ready_again", 32'(user_ready), 32'd1);

        // X moves first and wins on cells 0,1,2
        x_first = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();                                   // REQ_X
        check("xfirst_req", 32'(x_req), 32'd1);
        x_play(4'd0); tick(); tick();             // GET_USER
        user_play(4'd3); tick(); tick();          // REQ_X
        x_play(4'd1); tick(); tick();             // GET_USER
        user_play(4'd4); tick(); tick();          // REQ_X
        x_play(4'd2); tick();                     // CHECK_X
        result = 2'd1;
        disp_busy = 1'b1;
        tick();                                   // REPORT
        result = 2'd0;
        check("xwin_result", 32'(res_out), 32'd1);
        check("xwin_stb", 32'(result_stb), 32'd1);
        check("xwins_before", 32'(x_wins), 32'd0);
        tick();                                   // WAIT_DISP
        check("xwin_stb_single", 32'(result_stb), 32'd0);
        check("xwins_after", 32'(x_wins), SCORE_ON ? 32'd1 : 32'd0);
        check("xwins2_after", 32'(x_wins2), SCORE_ON ? 32'd1 : 32'd0);
        tick(); tick();                           // WAIT_DISP2 held by busy
        check("busy_hold_xreq", 32'(x_req), 32'd0);
        check("busy_hold_stb", 32'(result_stb), 32'd0);
        check("busy_hold_board", 32'(board), 32'h17F);
        check("busy_hold_result", 32'(res_out), 32'd1);
        disp_busy = 1'b0;
        tick();                                   // INIT
        check("init_xreq", 32'(x_req), 32'd0);
        check("init_board_held", 32'(board), 32'h17F);
        tick();                                   // REQ_X
        check("next_game_xreq", 32'(x_req), 32'd1);
        check("next_game_board", 32'(board), 32'd0);
        check("next_game_result", 32'(res_out), 32'd0);

        // engine plays onto an occupied cell
        x_play(4'd0); tick(); tick();             // GET_USER
        user_play(4'd5); tick(); tick();          // REQ_X
        check("err_pre_board", 32'(board), 32'h403);
        x_play(4'd5); tick();                     // ERROR
        check("err_stb", 32'(result_stb), 32'd0);
        check("err_board_held", 32'(board), 32'h403);
        tick();                                   // INIT
        check("err_init_stb", 32'(result_stb), 32'd0);
        tick();                                   // REQ_X
        check("err_board_clear", 32'(board), 32'd0);
        check("err_xwins_kept", 32'(x_wins), SCORE_ON ? 32'd1 : 32'd0);
        check("err_xreq", 32'(x_req), 32'd1);

        // reset mid-handshake while x_req is high
        x_play(4'd2); tick(); tick();             // GET_USER
        user_play(4'd6); tick(); tick();          // REQ_X
        check("mid_board", 32'(board), 32'h1030);
        check("mid_board2", board2, 32'h1030);
        x_first = 1'b0;
        rst_n = 1'b0;
        x_ack = 1'b1;
        x_move = 4'd7;
        tick();                                   // INIT
        rst_n = 1'b1;
        x_ack = 1'b0;
        check("mid_rst_xreq", 32'(x_req), 32'd0);
        check("mid_rst_xreq2", 32'(x_req2), 32'd0);
        check("mid_rst_board", 32'(board), 32'd0);
        check("mid_rst_board2", board2, 32'd0);
        check("mid_rst_ready", 32'(user_ready), 32'd0);
        check("mid_rst_xwins", 32'(x_wins), 32'd0);
        tick();                                   // GET_USER
        check("mid_rst_get_user", 32'(user_ready), 32'd1);

        // four draw games: 8-bit tally counts, 2-bit tally saturates
        for (int g = 0; g < 4; g++) begin
            user_play(4'(g));                     // APPLY_USER
            result = 2'd3;
            tick();                               // CHECK_USER
            tick();                               // REPORT
            result = 2'd0;
            check("draw_result", 32'(res_out), 32'd3);
            check("draw_stb", 32'(result_stb), 32'd1);
            tick();                               // WAIT_DISP
            check("draws_w8", 32'(draws), SCORE_ON ? 32'(g + 1) : 32'd0);
            check("draws_w2", 32'(draws2), SCORE_ON ? ((g < 3) ? 32'(g + 1) : 32'd3) : 32'd0);
            tick(); tick(); tick();               // WAIT_DISP2, INIT, GET_USER
        end
        check("draws_xwins", 32'(x_wins), 32'd0);

        // stray ack in GET_USER, stray valid in REQ_X
        x_ack = 1'b1;
        x_move = 4'd8;
        tick();
        x_ack = 1'b0;
        check("stray_ack_ready", 32'(user_ready), 32'd1);
        check("stray_ack_board", 32'(board), 32'd0);
        user_play(4'd4); tick(); tick();          // REQ_X
        user_valid = 1'b1;
        user_move = 4'd7;
        tick();
        user_valid = 1'b0;
        check("stray_valid_xreq", 32'(x_req), 32'd1);
        x_play(4'd0); tick(); tick();             // GET_USER
        check("stray_valid_board", 32'(board), 32'h103);

        // rejected user moves: out of range, then occupied
        user_play(4'd9);                          // APPLY_USER
        check("bad_range_pulse", 32'(bad_move), 32'd1);
        tick();                                   // GET_USER
        check("bad_range_clear", 32'(bad_move), 32'd0);
        check("bad_range_ready", 32'(user_ready), 32'd1);
        check("bad_range_board", 32'(board), 32'h103);
        user_play(4'd4);
        check("bad_occ_pulse", 32'(bad_move), 32'd1);
        tick();
        check("bad_occ_clear", 32'(bad_move), 32'd0);
        check("bad_occ_ready", 32'(user_ready), 32'd1);
        check("bad_occ_board", 32'(board), 32'h103);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ttt_game_ctrl.md
TTT_GAME_CTRL -- requirements
Module: ttt_game_ctrl

Interface
REQ-001 Parameter CELLS, default 9, number of board cells (legal range 4..16); board bus is 2*CELLS bits, cell k at bits [2k+1:2k].
REQ-002 Parameter MOVE_W, default 4, width of a cell index; SHALL satisfy 2**MOVE_W >= CELLS.
REQ-003 Parameter SCORE_W, default 8, width of each score counter.
REQ-004 Ports (name  direction  width  meaning): i_clk  in  1  sole clock; i_rst_n  in  1  synchronous active-low reset.
REQ-005 i_x_first  in  1  FPGA (X) moves first, sampled in INIT only.
REQ-006 i_user_valid  in  1; i_user_move  in  MOVE_W; o_user_ready  out  1; user move valid/ready handshake.
REQ-007 o_x_req  out  1; i_x_ack  in  1; i_x_move  in  MOVE_W; request/acknowledge to the external X move engine.
REQ-008 i_result  in  2  result of the external checker on o_board: 0 NONE, 1 XWIN, 2 OWIN, 3 DRAW.
REQ-009 i_disp_busy  in  1  display/UART busy; o_board  out  2*CELLS  board (00 empty, 01 O/user, 11 X/FPGA).
REQ-010 o_result  out  2  final result; o_result_stb  out  1  one-cycle result pulse; o_bad_move  out  1  one-cycle rejected-user-move pulse.
REQ-011 o_x_wins, o_o_wins, o_draws  out  SCORE_W  each, game tallies.

Function
REQ-012 States: INIT, GET_USER, APPLY_USER, CHECK_USER, REQ_X, APPLY_X, CHECK_X, REPORT, WAIT_DISP, WAIT_DISP2, ERROR.
REQ-013 INIT: clear o_board, clear o_result to 0, go to REQ_X if i_x_first else GET_USER; one cycle.
REQ-014 o_user_ready SHALL be high exactly while in GET_USER; transfer occurs on a cycle with i_user_valid && o_user_ready, capturing i_user_move; next state APPLY_USER.
REQ-015 APPLY_USER: if captured index >= CELLS or cell non-empty -> pulse o_bad_move for one cycle, board unchanged, return to GET_USER; else write 01 into the cell and go to CHECK_USER.
REQ-016 CHECK_USER samples i_result (reflecting the updated board): OWIN or DRAW -> latch into o_result, go to REPORT; XWIN -> ERROR; NONE -> REQ_X.
REQ-017 REQ_X: o_x_req held high until the cycle i_x_ack is sampled high; i_x_move captured on that cycle; o_x_req low from the next cycle; next state APPLY_X. No timeout.
REQ-018 APPLY_X: index >= CELLS or cell non-empty -> ERROR; else write 11 into the cell, go to CHECK_X.
REQ-019 CHECK_X: XWIN or DRAW -> latch o_result, go to REPORT; OWIN -> ERROR; NONE -> GET_USER.
REQ-020 REPORT: o_result_stb high for exactly this cycle; go to WAIT_DISP.
REQ-021 WAIT_DISP: one unconditional cycle (busy latency); WAIT_DISP2: remain until i_disp_busy low, then INIT.
REQ-022 ERROR: one cycle, then INIT; no score change, no o_result_stb.
REQ-023 o_result and o_board SHALL hold their values from REPORT until the next INIT.
REQ-024 Any unencoded state value SHALL go to INIT next cycle.
REQ-025 i_user_valid outside GET_USER and i_x_ack outside REQ_X SHALL be ignored.

Reset
REQ-026 On a clock edge with i_rst_n low, from any state including mid-handshake: state INIT, o_board 0, o_result 0, o_result_stb 0, o_bad_move 0, o_x_req 0, o_user_ready 0, all score counters 0.
REQ-027 Score counters SHALL be cleared only by reset, never by INIT.

Configuration
REQ-028 Macro TTT_SCORE_EN defined: in REPORT increment o_x_wins (XWIN), o_o_wins (OWIN) or o_draws (DRAW) by 1, saturating at all-ones.
REQ-029 Macro TTT_SCORE_EN undefined: no counter registers; o_x_wins, o_o_wins, o_draws tied to 0; all other behaviour identical.

Verification
REQ-030 i_x_first=0, user plays 4, engine acks 0 -> o_board cell4=01 then cell0=11; o_x_req low one cycle after ack.
REQ-031 User plays 9 (CELLS=9), then plays onto occupied cell 4 -> o_bad_move pulses once each, board unchanged, o_user_ready reasserted.
REQ-032 Board driven to X three-in-row, i_result=1 in CHECK_X -> o_result=1, single-cycle o_result_stb, o_x_wins 0->1 (TTT_SCORE_EN); INIT only after i_disp_busy falls.
REQ-033 Engine returns occupied cell -> ERROR then INIT; o_board cleared, scores unchanged, no o_result_stb.
REQ-034 SCORE_W=2, four DRAW games -> o_draws reads 1,2,3,3 (saturation); without TTT_SCORE_EN reads 0 throughout.
REQ-035 i_rst_n low for one cycle during REQ_X with o_x_req high -> next cycle o_x_req 0, board 0, state INIT; CELLS=16, MOVE_W=4 game completes identically.
